// File: rtl/galaksija_pkg.sv
// Shared Galaksija keyboard definitions: key-matrix indices, typist FSM states, mapped key payload.
package galaksija_pkg;

    localparam logic [5:0] KEY_ENTER = 6'd48;
    localparam logic [5:0] KEY_LEFT  = 6'd29;
    localparam logic [5:0] KEY_BREAK = 6'd49;
    localparam logic [5:0] KEY_SPACE = 6'd31;
    localparam logic [5:0] KEY_SHIFT = 6'd53;

    typedef enum logic [1:0] {
        IDLE,
        PRESS,
        GAP
    } fsm_state_t;

    typedef struct packed {
        logic       valid;
        logic       shift;
        logic [5:0] key;
    } key_code_t;

endpackage

// File: rtl/key_map.sv
// ASCII byte to Galaksija key-matrix index plus SHIFT; valid=0 for bytes with no key.
module key_map
    import galaksija_pkg::*;
(
    input  logic [7:0] data,
    output key_code_t  code_c
);

    always_comb begin
        code_c = '0;
        if (data >= 8'h41 && data <= 8'h5A) begin
            code_c = '{valid: 1'b1, shift: 1'b0, key: 6'(data - 8'h40)};
        end else if (data >= 8'h61 && data <= 8'h7A) begin
            code_c = '{valid: 1'b1, shift: 1'b0, key: 6'(data - 8'h60)};
        end else if (data >= 8'h30 && data <= 8'h39) begin
            // '0'..'9' land on 32..41
            code_c = '{valid: 1'b1, shift: 1'b0, key: 6'(data - 8'h10)};
        end else begin
            case (data)
                8'h0A, 8'h0D: code_c = '{1'b1, 1'b0, KEY_ENTER};
                8'h08, 8'h7F: code_c = '{1'b1, 1'b0, KEY_LEFT};
                8'h1B:        code_c = '{1'b1, 1'b0, KEY_BREAK};
                8'h20:        code_c = '{1'b1, 1'b0, KEY_SPACE};
                8'h5F:        code_c = '{1'b1, 1'b1, 6'd32};
                8'h21:        code_c = '{1'b1, 1'b1, 6'd33};
                8'h22:        code_c = '{1'b1, 1'b1, 6'd34};
                8'h23:        code_c = '{1'b1, 1'b1, 6'd35};
                8'h24:        code_c = '{1'b1, 1'b1, 6'd36};
                8'h25:        code_c = '{1'b1, 1'b1, 6'd37};
                8'h26:        code_c = '{1'b1, 1'b1, 6'd38};
                8'h5C:        code_c = '{1'b1, 1'b1, 6'd39};
                8'h28:        code_c = '{1'b1, 1'b1, 6'd40};
                8'h29:        code_c = '{1'b1, 1'b1, 6'd41};
                8'h2B:        code_c = '{1'b1, 1'b1, 6'd42};
                8'h2A:        code_c = '{1'b1, 1'b1, 6'd43};
                8'h3C:        code_c = '{1'b1, 1'b1, 6'd44};
                8'h2D:        code_c = '{1'b1, 1'b1, 6'd45};
                8'h3E:        code_c = '{1'b1, 1'b1, 6'd46};
                8'h3F:        code_c = '{1'b1, 1'b1, 6'd47};
                8'h3B:        code_c = '{1'b1, 1'b0, 6'd42};
                8'h3A:        code_c = '{1'b1, 1'b0, 6'd43};
                8'h2C:        code_c = '{1'b1, 1'b0, 6'd44};
                8'h3D:        code_c = '{1'b1, 1'b0, 6'd45};
                8'h2E:        code_c = '{1'b1, 1'b0, 6'd46};
                8'h2F:        code_c = '{1'b1, 1'b0, 6'd47};
                default:      code_c = '0;
            endcase
        end
    end

endmodule

// File: rtl/key_typist.sv
// Queues received bytes and types each as a timed key press/release pair into the CPU keyboard window.
module key_typist
    import galaksija_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 1500000,
    parameter int unsigned GAP_CYCLES  = 1000000,
    parameter int unsigned FIFO_AW     = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       flush,
    input  logic       key_rd,
    input  logic [5:0] key_addr,
    output logic [7:0] key_out,
    output logic       busy,
    output logic       overflow
);

    localparam int unsigned DEPTH      = 2 ** FIFO_AW;
    localparam int unsigned PTR_W      = FIFO_AW;
    localparam int unsigned FILL_W     = FIFO_AW + 1;
    localparam int unsigned MAX_CYCLES = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CNT_W-1:0]  HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [FILL_W-1:0] FULL_FILL = FILL_W'(DEPTH);

    logic [7:0]        fifo_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [FILL_W-1:0] count, count_next;
    fsm_state_t        state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic [5:0]        cur_key, key_next;
    logic              cur_shift, shift_next;
    logic              push, pop, drop, full;
    logic              pressed_c;
    key_code_t         code_c;

    key_map u_key_map (
        .data   (fifo_mem[rd_ptr]),
        .code_c (code_c)
    );

    // Next-state: FIFO bookkeeping and press/gap sequencing; flush overrides everything
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        key_next   = cur_key;
        shift_next = cur_shift;
        pop        = 1'b0;
        count_next = count;

        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop = 1'b1;
                    if (code_c.valid) begin
                        key_next   = code_c.key;
                        shift_next = code_c.shift;
                        cnt_next   = HOLD_LOAD;
                        state_next = PRESS;
                    end
                end
            end
            PRESS: begin
                if (cnt == '0) begin
                    cnt_next   = GAP_LOAD;
                    state_next = GAP;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase

        full = (count == FULL_FILL);
        push = rx_valid && (!full || pop);
        drop = rx_valid && full && !pop;

        if (flush) begin
            state_next = IDLE;
            cnt_next   = '0;
            pop        = 1'b0;
            push       = 1'b0;
            drop       = 1'b0;
        end

        case ({push, pop})
            2'b10:   count_next = count + FILL_W'(1);
            2'b01:   count_next = count - FILL_W'(1);
            default: count_next = count;
        endcase
        if (flush) begin
            count_next = '0;
        end
    end

    assign pressed_c = (state == PRESS) && !flush &&
                       ((key_addr == cur_key) || (cur_shift && key_addr == KEY_SHIFT));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            cur_key   <= '0;
            cur_shift <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            key_out   <= 8'hFF;
            busy      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            cur_key   <= key_next;
            cur_shift <= shift_next;
            count     <= count_next;
            busy      <= (state_next != IDLE) || (count_next != '0);
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (drop) overflow <= 1'b1;
            if (key_rd) key_out <= pressed_c ? 8'hFE : 8'hFF;
        end
    end

    // Storage needs no reset: entries are only read after being written
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= rx_data;
    end

endmodule

// File: tb/tb_key_typist.sv
// Directed bench for key_typist with short hold/gap times; press windows are observed via per-cycle key reads.
module tb_key_typist;

    logic       clk;
    logic       reset_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       flush;
    logic       key_rd;
    logic [5:0] key_addr;
    logic [7:0] key_out;
    logic       busy;
    logic       overflow;

    int checks;
    int errors;

    key_typist #(
        .HOLD_CYCLES (4),
        .GAP_CYCLES  (3),
        .FIFO_AW     (4)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .flush    (flush),
        .key_rd   (key_rd),
        .key_addr (key_addr),
        .key_out  (key_out),
        .busy     (busy),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  data;
        logic [5:0]  addr;
        logic [15:0] exp_key;
        logic [15:0] exp_busy;
    } vec_t;

    vec_t vecs[16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    // Read one address for n cycles; bit i = key pressed in read cycle i, busy seen after it
    task automatic probe(input logic [5:0] addr, input int n,
                         output logic [15:0] kpat, output logic [15:0] bpat);
        kpat = '0;
        bpat = '0;
        for (int i = 0; i < n; i++) begin
            key_rd   = 1'b1;
            key_addr = addr;
            tick();
            kpat[i] = (key_out == 8'hFE);
            bpat[i] = busy;
        end
        key_rd = 1'b0;
    endtask

    logic [15:0] kp, bp;
    int          j;
    logic        exp_fe;

    initial begin
        checks   = 0;
        errors   = 0;
        reset_n  = 1'b0;
        rx_data  = '0;
        rx_valid = 1'b0;
        flush    = 1'b0;
        key_rd   = 1'b0;
        key_addr = '0;

        vecs[0]  = '{8'h41, 6'd1,  16'h001E, 16'h007F};
        vecs[1]  = '{8'h41, 6'd2,  16'h0000, 16'h007F};
        vecs[2]  = '{8'h21, 6'd33, 16'h001E, 16'h007F};
        vecs[3]  = '{8'h21, 6'd53, 16'h001E, 16'h007F};
        vecs[4]  = '{8'h21, 6'd1,  16'h0000, 16'h007F};
        vecs[5]  = '{8'h3B, 6'd42, 16'h001E, 16'h007F};
        vecs[6]  = '{8'h3B, 6'd53, 16'h0000, 16'h007F};
        vecs[7]  = '{8'h7A, 6'd26, 16'h001E, 16'h007F};
        vecs[8]  = '{8'h35, 6'd37, 16'h001E, 16'h007F};
        vecs[9]  = '{8'h0D, 6'd48, 16'h001E, 16'h007F};
        vecs[10] = '{8'h7F, 6'd29, 16'h001E, 16'h007F};
        vecs[11] = '{8'h20, 6'd31, 16'h001E, 16'h007F};
        vecs[12] = '{8'h5F, 6'd32, 16'h001E, 16'h007F};
        vecs[13] = '{8'h2F, 6'd47, 16'h001E, 16'h007F};
        vecs[14] = '{8'h7E, 6'd1,  16'h0000, 16'h0000};
        vecs[15] = '{8'h27, 6'd34, 16'h0000, 16'h0000};

        tick();
        tick();
        reset_n = 1'b1;
        check("reset key_out", 32'(key_out), 32'hFF);
        check("reset busy", 32'(busy), 32'h0);
        check("reset overflow", 32'(overflow), 32'h0);

        foreach (vecs[k]) begin
            send(vecs[k].data);
            check($sformatf("vec%0d busy after push", k), 32'(busy), 32'h1);
            probe(vecs[k].addr, 10, kp, bp);
            check($sformatf("vec%0d press window", k), 32'(kp), 32'(vecs[k].exp_key));
            check($sformatf("vec%0d busy window", k), 32'(bp), 32'(vecs[k].exp_busy));
        end

        // Repeated character: two windows 8 cycles apart
        send(8'h61);
        send(8'h61);
        probe(6'd1, 16, kp, bp);
        check("aa press windows", 32'(kp), 32'h0F0F);
        check("aa busy", 32'(bp), 32'h3FFF);

        // Unmapped byte costs one IDLE pop before the next character
        send(8'h7E);
        send(8'h35);
        probe(6'd37, 10, kp, bp);
        check("7E5 press window", 32'(kp), 32'h001E);
        check("7E5 busy", 32'(bp), 32'h007F);

        // Flood while typing: 'b' then 'A'..'T'; 'S','T' dropped
        send(8'h62);
        tick();
        for (int t = 2; t < 160; t++) begin
            j = (t - 2) / 8;
            if (j > 19) j = 19;
            rx_valid = (t <= 21);
            rx_data  = 8'(8'h41 + t - 2);
            key_rd   = 1'b1;
            key_addr = (j == 0) ? 6'd2 : 6'(j);
            exp_fe   = (j <= 18) && (((t - 2) % 8) < 4);
            tick();
            check($sformatf("flood t%0d key%0d", t, key_addr), 32'(key_out),
                  exp_fe ? 32'hFE : 32'hFF);
            if (t == 19) check("overflow before drop", 32'(overflow), 32'h0);
            if (t == 20) check("overflow after drop", 32'(overflow), 32'h1);
        end
        rx_valid = 1'b0;
        key_rd   = 1'b0;
        check("flood busy done", 32'(busy), 32'h0);
        check("flood overflow sticky", 32'(overflow), 32'h1);

        // Flush during PRESS of 'd' with 'e'..'i' still queued
        send(8'h63);
        for (int i = 0; i < 6; i++) send(8'(8'h64 + i));
        tick();
        tick();
        tick();
        key_rd   = 1'b1;
        key_addr = 6'd4;
        tick();
        check("pre-flush press d", 32'(key_out), 32'hFE);
        key_rd   = 1'b0;
        flush    = 1'b1;
        rx_data  = 8'h6A;
        rx_valid = 1'b1;
        tick();
        flush    = 1'b0;
        rx_valid = 1'b0;
        check("key_out holds", 32'(key_out), 32'hFE);
        check("flush busy", 32'(busy), 32'h0);
        check("flush overflow unchanged", 32'(overflow), 32'h1);
        key_rd   = 1'b1;
        key_addr = 6'd4;
        tick();
        key_rd = 1'b0;
        check("post-flush release", 32'(key_out), 32'hFF);
        probe(6'd5, 12, kp, bp);
        check("flushed e not typed", 32'(kp), 32'h0);
        check("flushed busy", 32'(bp), 32'h0);
        probe(6'd10, 12, kp, bp);
        check("dropped j not typed", 32'(kp), 32'h0);

        // Reset in the middle of a press with a byte queued
        send(8'h41);
        send(8'h42);
        key_rd   = 1'b1;
        key_addr = 6'd1;
        tick();
        key_rd = 1'b0;
        check("pre-reset press A", 32'(key_out), 32'hFE);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("mid reset key_out", 32'(key_out), 32'hFF);
        check("mid reset busy", 32'(busy), 32'h0);
        check("mid reset overflow", 32'(overflow), 32'h0);
        probe(6'd1, 1, kp, bp);
        check("A released after reset", 32'(kp), 32'h0);
        probe(6'd2, 12, kp, bp);
        check("queued B lost", 32'(kp), 32'h0);
        check("busy idle after reset", 32'(bp), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
